bus_xfer_ctrl: RTL

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_ctrl_pkg.sv | 20 ++
 rtl/bus_xfer_ctrl_if.sv | 28 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/bus_xfer_ctrl.sv | 101 ++++++++++
 4 files changed

// File: rtl/bus_ctrl_pkg.sv
// Shared types for the register-to-register bus transfer controller.
// Record fields are sized for up to 256 registers and 256 requesters.
package bus_ctrl_pkg;

  localparam int unsigned IDX_W_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_LATCH,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [IDX_W_MAX-1:0] rid;
    logic [IDX_W_MAX-1:0] src;
    logic [IDX_W_MAX-1:0] dst;
  } xfer_t;

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Requester and register-bank signals of the bus transfer controller.
// The master modport is the requester side; the slave modport is the controller.
interface bus_xfer_ctrl_if #(
  parameter int unsigned NREG = 8,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IW = $clog2(NREG);

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0][IW-1:0] req_src;
  logic [NREQ-1:0][IW-1:0] req_dst;
  logic [NREQ-1:0]         ack;
  logic [NREQ-1:0]         err;
  logic [NREG-1:0]         reg_en;
  logic [NREG-1:0]         reg_set;
  logic                    busy;

  modport master (
    output req, req_src, req_dst,
    input  ack, err, reg_en, reg_set, busy
  );

  modport slave (
    input  req, req_src, req_dst,
    output ack, err, reg_en, reg_set, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last accepted grant.
// After reset the pointer sits on NREQ-1, so requester 0 has top priority.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] grant_c,
  output logic [PW-1:0]   gidx_c
);

  logic [PW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= PW'(NREQ - 1);
    end else if (accept) begin
      ptr <= gidx_c;
    end
  end

  // First requesting index walking forward from ptr+1, wrapping modulo NREQ.
  always_comb begin
    logic          found;
    logic [PW-1:0] k;
    int            idx;
    grant_c = '0;
    gidx_c  = '0;
    found   = 1'b0;
    k       = '0;
    idx     = 0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      idx = (int'(ptr) + i) % int'(NREQ);
      k   = PW'(idx);
      if (!found && req[k]) begin
        found      = 1'b1;
        gidx_c     = k;
        grant_c[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences one register-to-register move over a shared tri-state bus:
// drive the source, strobe the destination, hold, then ack the requester.
module bus_xfer_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned NREG = 8,
  parameter int unsigned NREQ = 4
) (
  input logic            clk,
  input logic            rst_n,
  bus_xfer_ctrl_if.slave bus
);

  localparam int unsigned IW = $clog2(NREG);
  localparam int unsigned PW = $clog2(NREQ);

  state_e          state, state_nx;
  xfer_t           xfer, xfer_nx;
  logic [NREG-1:0] reg_en_nx, reg_set_nx;
  logic [NREQ-1:0] ack_nx, err_nx;
  logic            busy_nx;
  logic [NREQ-1:0] grant_c;
  logic [PW-1:0]   gidx_c;
  logic            accept_c;
  logic [IW-1:0]   sel_src_c, sel_dst_c;

  assign accept_c  = (state == ST_IDLE) && (|grant_c);
  assign sel_src_c = bus.req_src[gidx_c];
  assign sel_dst_c = bus.req_dst[gidx_c];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .accept  (accept_c),
    .grant_c (grant_c),
    .gidx_c  (gidx_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      xfer        <= '0;
      bus.reg_en  <= '0;
      bus.reg_set <= '0;
      bus.ack     <= '0;
      bus.err     <= '0;
      bus.busy    <= 1'b0;
    end else begin
      state       <= state_nx;
      xfer        <= xfer_nx;
      bus.reg_en  <= reg_en_nx;
      bus.reg_set <= reg_set_nx;
      bus.ack     <= ack_nx;
      bus.err     <= err_nx;
      bus.busy    <= busy_nx;
    end
  end

  // Outputs are decoded for the state being entered so they land registered.
  always_comb begin
    state_nx   = state;
    xfer_nx    = xfer;
    reg_en_nx  = '0;
    reg_set_nx = '0;
    ack_nx     = '0;
    err_nx     = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nx     = ST_DRIVE;
          xfer_nx.rid  = IDX_W_MAX'(gidx_c);
          xfer_nx.src  = IDX_W_MAX'(sel_src_c);
          xfer_nx.dst  = IDX_W_MAX'(sel_dst_c);
          if (sel_src_c != sel_dst_c) reg_en_nx = NREG'(1) << sel_src_c;
        end
      end
      ST_DRIVE: begin
        state_nx = ST_LATCH;
        if (xfer.src != xfer.dst) begin
          reg_en_nx  = NREG'(1) << xfer.src;
          reg_set_nx = NREG'(1) << xfer.dst;
        end
      end
      ST_LATCH: begin
        state_nx = ST_HOLD;
        ack_nx   = NREQ'(1) << xfer.rid;
        if (xfer.src != xfer.dst) reg_en_nx = NREG'(1) << xfer.src;
        else                      err_nx    = NREQ'(1) << xfer.rid;
      end
      ST_HOLD: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

endmodule
